ne16_pres_accumulator: RTL and testbench

Receiving end of the binconv array partial-result interface. It sinks the NR_COLUMN column partial-result streams under one shared handshake and accumulates a programmed number of beats into per-column signed accumulators. It then drains the accumulators as a serialized 32-bit stream toward normalization/quantization. It sits directly downstream of the binconv array in the NE16 datapath.

---
 rtl/ne16_pres_accumulator.sv | 142 ++++++++++++++
 tb/tb_ne16_pres_accumulator.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ne16_pres_accumulator.sv
// ne16_pres_accumulator: sinks the binconv column partial results,
// accumulates one job of beats per column, then drains them serially.
module ne16_pres_accumulator #(
  parameter int unsigned NR_COLUMN  = 9,
  parameter int unsigned PRES_WIDTH = 30,
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                enable_i,
  input  logic                                clear_i,
  input  logic [NR_COLUMN-1:0]                pres_valid_i,
  input  logic [NR_COLUMN-1:0][PRES_WIDTH-1:0] pres_data_i,
  output logic [NR_COLUMN-1:0]                pres_ready_o,
  output logic                                acc_valid_o,
  output logic [ACC_WIDTH-1:0]                acc_data_o,
  output logic [ACC_WIDTH/8-1:0]              acc_strb_o,
  input  logic                                acc_ready_i,
  input  logic                                ctrl_start_i,
  input  logic [CNT_WIDTH-1:0]                ctrl_nb_accum_i,
  input  logic                                ctrl_mode_linear_i,
  output logic                                flags_busy_o,
  output logic                                flags_done_o
);

  localparam int unsigned IDX_W =
    (NR_COLUMN > 1) ? $clog2(NR_COLUMN) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e                               r_state;
  logic [NR_COLUMN-1:0][ACC_WIDTH-1:0]  r_acc;
  logic [CNT_WIDTH-1:0]                 r_cnt;
  logic [CNT_WIDTH-1:0]                 r_nb;
  logic                                 r_lin;
  logic [IDX_W-1:0]                     r_idx;
  logic                                 r_done;

  logic                                 w_hs;
  logic                                 w_last_beat;
  logic                                 w_last_idx;
  logic                                 w_start;
  logic [IDX_W-1:0]                     w_max_idx;
  logic [NR_COLUMN-1:0][ACC_WIDTH-1:0]  w_sext;
  logic                                 w_unused;

  // Only column 0 carries the shared valid; the rest are don't-care.
  assign w_unused = ^pres_valid_i[NR_COLUMN-1:1];

  assign w_hs        = (r_state == ACCUM) & pres_valid_i[0] & enable_i;
  assign w_last_beat = (r_cnt == (r_nb - CNT_WIDTH'(1)));
  assign w_max_idx   = r_lin ? '0 : IDX_W'(NR_COLUMN - 1);
  assign w_last_idx  = (r_idx == w_max_idx);
  assign w_start     = (r_state == IDLE) & ctrl_start_i;

  assign pres_ready_o = {NR_COLUMN{(r_state == ACCUM) & enable_i}};
  assign acc_valid_o  = (r_state == DRAIN);
  assign acc_data_o   = acc_valid_o ? r_acc[r_idx] : '0;
  assign acc_strb_o   = '1;
  assign flags_busy_o = (r_state != IDLE);
  assign flags_done_o = r_done;

  // Sign-extend every column partial result to accumulator width.
  always_comb begin
    w_sext = '0;
    for (int c = 0; c < NR_COLUMN; c++) begin
      w_sext[c] = ACC_WIDTH'($signed(pres_data_i[c]));
    end
  end

  // Job control: state, beat counter, drain index and done pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_nb    <= '0;
      r_lin   <= 1'b0;
      r_idx   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (clear_i) begin
        r_state <= IDLE;
        r_cnt   <= '0;
        r_idx   <= '0;
      end else begin
        unique case (r_state)
          IDLE: begin
            if (ctrl_start_i) begin
              r_nb    <= ctrl_nb_accum_i;
              r_lin   <= ctrl_mode_linear_i;
              r_cnt   <= '0;
              r_idx   <= '0;
              r_state <= (ctrl_nb_accum_i == '0) ? DRAIN : ACCUM;
            end
          end
          ACCUM: begin
            if (w_hs) begin
              r_cnt <= r_cnt + CNT_WIDTH'(1);
              if (w_last_beat) begin
                r_state <= DRAIN;
              end
            end
          end
          DRAIN: begin
            if (acc_ready_i) begin
              if (w_last_idx) begin
                r_state <= IDLE;
                r_idx   <= '0;
                r_done  <= 1'b1;
              end else begin
                r_idx <= r_idx + IDX_W'(1);
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  // Per-column accumulators; linear jobs touch column 0 only.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_acc <= '0;
    end else if (clear_i || w_start) begin
      r_acc <= '0;
    end else if (w_hs) begin
      for (int c = 0; c < NR_COLUMN; c++) begin
        if (!r_lin || c == 0) begin
          r_acc[c] <= r_acc[c] + w_sext[c];
        end
      end
    end
  end

endmodule

// File: tb/tb_ne16_pres_accumulator.sv
// tb_ne16_pres_accumulator: directed and randomized jobs checked
// against an arithmetic per-column sum model.
module tb_ne16_pres_accumulator;

  localparam int NRC = 9;
  localparam int PW  = 30;
  localparam int AW  = 32;
  localparam int CW  = 16;
  localparam int BOUND = 4000;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     en;
  logic                     clr;
  logic [NRC-1:0]           pv;
  logic [NRC-1:0][PW-1:0]   pd;
  logic [NRC-1:0]           prdy;
  logic                     av;
  logic [AW-1:0]            ad;
  logic [AW/8-1:0]          as;
  logic                     ardy;
  logic                     st;
  logic [CW-1:0]            nb;
  logic                     lin;
  logic                     busy;
  logic                     done;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  logic [NRC-1:0][PW-1:0] beats_q[$];
  longint sum[NRC];

  always #5 clk = ~clk;

  ne16_pres_accumulator #(
    .NR_COLUMN (NRC),
    .PRES_WIDTH(PW),
    .ACC_WIDTH (AW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .enable_i          (en),
    .clear_i           (clr),
    .pres_valid_i      (pv),
    .pres_data_i       (pd),
    .pres_ready_o      (prdy),
    .acc_valid_o       (av),
    .acc_data_o        (ad),
    .acc_strb_o        (as),
    .acc_ready_i       (ardy),
    .ctrl_start_i      (st),
    .ctrl_nb_accum_i   (nb),
    .ctrl_mode_linear_i(lin),
    .flags_busy_o      (busy),
    .flags_done_o      (done)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NRC-1:0][PW-1:0] fill(input int v);
    logic [NRC-1:0][PW-1:0] b;
    for (int c = 0; c < NRC; c++) b[c] = PW'(v);
    return b;
  endfunction

  function automatic logic [NRC-1:0][PW-1:0] rnd_beat();
    logic [NRC-1:0][PW-1:0] b;
    for (int c = 0; c < NRC; c++) b[c] = PW'($urandom);
    return b;
  endfunction

  // en_mode: 0 always on, 1 alternate, 2 random (valid random too)
  // rdy_mode: 0 always, 1 random, 2 low for the first 7 cycles
  task automatic run_job(input int nbv, input bit linv,
                         input int en_mode, input int rdy_mode,
                         input bit poke);
    int k;
    int cyc;
    int idx;
    int last;
    logic [AW-1:0] e;
    for (int c = 0; c < NRC; c++) sum[c] = 0;
    @(negedge clk);
    st = 1'b1; nb = CW'(nbv); lin = linv;
    @(negedge clk);
    st = 1'b0; nb = CW'($urandom); lin = 1'($urandom);
    k = 0; cyc = 0;
    while (k < nbv && cyc < BOUND) begin
      case (en_mode)
        0:       en = 1'b1;
        1:       en = 1'(cyc % 2);
        default: en = 1'($urandom);
      endcase
      pv = NRC'($urandom);
      pv[0] = (en_mode == 2) ? 1'($urandom) : 1'b1;
      pd = (beats_q.size() > 0) ? beats_q[0] : rnd_beat();
      st = poke ? 1'($urandom) : 1'b0;
      ardy = 1'($urandom);
      #1;
      chk("accum_busy", busy, 1);
      chk("accum_ready", prdy, {NRC{en}});
      chk("accum_valid_low", av, 0);
      if (pv[0] && en) begin
        for (int c = 0; c < NRC; c++)
          if (!linv || c == 0) sum[c] += longint'($signed(pd[c]));
        if (beats_q.size() > 0) void'(beats_q.pop_front());
        k++;
      end
      @(negedge clk);
      cyc++;
    end
    if (cyc >= BOUND) chk("accum_timeout", cyc, 0);
    st = 1'b0; pv = '0; en = 1'($urandom);
    last = linv ? 0 : NRC - 1;
    idx = 0; cyc = 0;
    while (idx <= last && cyc < BOUND) begin
      case (rdy_mode)
        0:       ardy = 1'b1;
        1:       ardy = 1'($urandom);
        default: ardy = (cyc >= 7);
      endcase
      e = sum[idx][AW-1:0];
      chk("drain_valid", av, 1);
      chk($sformatf("drain_data%0d", idx), ad, e);
      chk("drain_strb", as, {(AW/8){1'b1}});
      chk("drain_done_low", done, 0);
      if (ardy) idx++;
      @(negedge clk);
      cyc++;
    end
    if (cyc >= BOUND) chk("drain_timeout", cyc, 0);
    chk("done_pulse", done, 1);
    chk("busy_drop", busy, 0);
    chk("valid_drop", av, 0);
    @(negedge clk);
    chk("done_once", done, 0);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; pv = '0; pd = '0;
    ardy = 1'b0; st = 1'b0; nb = '0; lin = 1'b0;
    #12;
    chk("rst_valid", av, 0);
    chk("rst_data", ad, 0);
    chk("rst_ready", prdy, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // basic: data c+1 for 3 beats -> 3,6,...,27
    for (int b = 0; b < 3; b++) begin
      logic [NRC-1:0][PW-1:0] v;
      for (int c = 0; c < NRC; c++) v[c] = PW'(c + 1);
      beats_q.push_back(v);
    end
    run_job(3, 0, 0, 0, 0);
    chk("basic_model_c8", sum[8], 27);

    // signed: -5 then -7 in column 0
    beats_q.push_back(fill(-5));
    beats_q.push_back(fill(-7));
    run_job(2, 0, 0, 1, 0);
    chk("signed_model", sum[0][31:0], 32'hFFFFFFF4);

    // large positives, then wrap
    repeat (4) beats_q.push_back(fill(32'h1FFFFFFF));
    run_job(4, 0, 0, 0, 0);
    chk("big4_model", sum[0][31:0], 32'h7FFFFFFC);
    repeat (5) beats_q.push_back(fill(32'h1FFFFFFF));
    run_job(5, 0, 0, 0, 0);
    chk("wrap5_model", sum[0][31:0], 32'h9FFFFFFB);

    // linear mode: one beat of 40
    repeat (4) beats_q.push_back(fill(10));
    run_job(4, 1, 0, 0, 0);

    // stalled vs unstalled, same data; ready held low 7 cycles
    begin
      logic [NRC-1:0][PW-1:0] sv[5];
      for (int b = 0; b < 5; b++) sv[b] = rnd_beat();
      for (int b = 0; b < 5; b++) beats_q.push_back(sv[b]);
      run_job(5, 0, 0, 0, 0);
      for (int b = 0; b < 5; b++) beats_q.push_back(sv[b]);
      run_job(5, 0, 1, 2, 0);
    end

    // clear after 2 of 5 beats
    @(negedge clk);
    st = 1'b1; nb = 5; lin = 1'b0;
    @(negedge clk);
    st = 1'b0; en = 1'b1; pv = '1; pd = rnd_beat();
    @(negedge clk);
    pd = rnd_beat();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0; pv = '0;
    #1;
    chk("clr_accum_busy", busy, 0);
    chk("clr_accum_ready", prdy, 0);
    chk("clr_accum_valid", av, 0);
    beats_q.push_back(fill(4));
    run_job(1, 0, 0, 0, 0);

    // clear in DRAIN at idx 3
    @(negedge clk);
    st = 1'b1; nb = 1; lin = 1'b0;
    @(negedge clk);
    st = 1'b0; en = 1'b1; pv = '1; pd = rnd_beat(); ardy = 1'b1;
    @(negedge clk);
    pv = '0;
    repeat (3) @(negedge clk);
    chk("pre_clr_valid", av, 1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("clr_drain_valid", av, 0);
      chk("clr_drain_done", done, 0);
      @(negedge clk);
    end

    // zero-beat job drains zeros; start pokes ignored during ACCUM
    run_job(0, 0, 0, 1, 0);
    run_job(6, 0, 2, 1, 1);

    // async reset in DRAIN
    @(negedge clk);
    st = 1'b1; nb = 1; lin = 1'b0;
    @(negedge clk);
    st = 1'b0; en = 1'b1; pv = '1; pd = fill(3); ardy = 1'b0;
    @(negedge clk);
    pv = '0;
    chk("pre_rst_valid", av, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", av, 0);
    chk("arst_busy", busy, 0);
    chk("arst_data", ad, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // randomized jobs
    for (int j = 0; j < 8; j++) begin
      run_job($urandom_range(1, 7), 1'($urandom),
              $urandom_range(0, 2), $urandom_range(0, 2),
              1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
